// File: rtl/spi_master_core.sv
// SPI mode-0 master (MSB first) with start/done handshake and sck derived from clk_i.
// Define SPI_BURST_EN to allow back-to-back frames with cs_o held low.
module spi_master_core #(
  parameter int MAX_PIXEL_BITS = 8,
  parameter int DATA_BITS      = MAX_PIXEL_BITS,
  parameter int CLK_DIV        = 4
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] data_tx_i,
  output logic [DATA_BITS-1:0] data_rx_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 sck_o,
  output logic                 cs_o,
  output logic                 sdo_o,
  input  logic                 sdi_i
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [CW-1:0] DivLast  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DivFull  = CW'(CLK_DIV);
  localparam logic [BW-1:0] BitOne   = BW'(1);
  localparam logic [BW-1:0] BitsLast = BW'(DATA_BITS);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StSckHi = 3'd2;
  localparam logic [2:0] StSckLo = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StGap   = 3'd5;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] tx_sr;
  logic [DATA_BITS-1:0] rx_sr;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state     <= StIdle;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      data_rx_o <= '0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
      sck_o     <= 1'b0;
      cs_o      <= 1'b1;
      sdo_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        StIdle: begin
          if (start_i) begin
            tx_sr   <= data_tx_i;
            busy_o  <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= StSetup;
          end
        end
        StSetup: begin
          // First SETUP cycle drives cs/MSB; the wait that follows is CLK_DIV cycles long.
          if (cnt == '0) begin
            cs_o  <= 1'b0;
            sdo_o <= tx_sr[DATA_BITS-1];
          end
          if (cnt == DivFull) begin
            cnt     <= '0;
            sck_o   <= 1'b1;
            rx_sr   <= {rx_sr[DATA_BITS-2:0], sdi_i};
            bit_cnt <= bit_cnt + BitOne;
            state   <= StSckHi;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StSckHi: begin
          if (cnt == DivLast) begin
            cnt   <= '0;
            sck_o <= 1'b0;
            if (bit_cnt == BitsLast) begin
              sdo_o <= 1'b0;
              state <= StHold;
            end else begin
              tx_sr <= {tx_sr[DATA_BITS-2:0], 1'b0};
              sdo_o <= tx_sr[DATA_BITS-2];
              state <= StSckLo;
            end
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StSckLo: begin
          if (cnt == DivLast) begin
            cnt     <= '0;
            sck_o   <= 1'b1;
            rx_sr   <= {rx_sr[DATA_BITS-2:0], sdi_i};
            bit_cnt <= bit_cnt + BitOne;
            state   <= StSckHi;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StHold: begin
          if (cnt == DivLast) begin
            cnt       <= '0;
            done_o    <= 1'b1;
            data_rx_o <= rx_sr;
`ifdef SPI_BURST_EN
            if (start_i) begin
              // Chained frame: cs stays low and MSB is already on sdo, so skip the setup drive.
              tx_sr   <= data_tx_i;
              sdo_o   <= data_tx_i[DATA_BITS-1];
              bit_cnt <= '0;
              cnt     <= CntOne;
              state   <= StSetup;
            end else begin
              cs_o  <= 1'b1;
              state <= StGap;
            end
`else
            cs_o  <= 1'b1;
            state <= StGap;
`endif
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StGap: begin
          if (cnt == DivLast) begin
            cnt    <= '0;
            busy_o <= 1'b0;
            state  <= StIdle;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: loopback, peripheral model, busy-start, reset, CLK_DIV=1, burst.
module tb_spi_master_core;
  logic       clk = 1'b0;
  logic       nreset, start, start1, loop;
  logic [7:0] data_tx, data_tx1, data_rx, data_rx1;
  logic       done, busy, sck, cs, sdo, sdi;
  logic       done1, busy1, sck1, cs1, sdo1;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  spi_master_core #(.MAX_PIXEL_BITS(8), .DATA_BITS(8), .CLK_DIV(4)) dut (
    .clk_i(clk), .nreset_i(nreset), .start_i(start), .data_tx_i(data_tx),
    .data_rx_o(data_rx), .done_o(done), .busy_o(busy), .sck_o(sck), .cs_o(cs),
    .sdo_o(sdo), .sdi_i(sdi)
  );

  spi_master_core #(.MAX_PIXEL_BITS(8), .DATA_BITS(8), .CLK_DIV(1)) dut1 (
    .clk_i(clk), .nreset_i(nreset), .start_i(start1), .data_tx_i(data_tx1),
    .data_rx_o(data_rx1), .done_o(done1), .busy_o(busy1), .sck_o(sck1), .cs_o(cs1),
    .sdo_o(sdo1), .sdi_i(sdo1)
  );

  // Mode-0 peripheral: replies 0x3C, shifts out on falling sck, samples on rising sck.
  logic [7:0] p_tx = 8'h3C;
  logic [7:0] p_rx = 8'h00;
  int         sck_rises = 0;
  always @(negedge sck or posedge cs) begin
    if (cs) p_tx <= 8'h3C;
    else    p_tx <= {p_tx[6:0], 1'b0};
  end
  always @(posedge sck) begin
    if (!cs) begin
      p_rx <= {p_rx[6:0], sdo};
      sck_rises++;
    end
  end
  assign sdi = loop ? sdo : p_tx[7];

  // sdo must hold its value in the cycle before and the cycle after every rising sck.
  logic sck_prev = 1'b0, sdo_prev = 1'b0, rose_last = 1'b0;
  int   sdo_bad = 0;
  always @(negedge clk) begin
    if (!cs && nreset === 1'b1) begin
      if (sck && !sck_prev && sdo !== sdo_prev) sdo_bad++;
      if (rose_last && sdo !== sdo_prev) sdo_bad++;
    end
    rose_last = sck && !sck_prev;
    sck_prev  = sck;
    sdo_prev  = sdo;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves cyc = 0 just after the accepting edge; data_tx is scrambled afterwards.
  task automatic accept(input logic [7:0] d);
    data_tx = d;
    start   = 1'b1;
    step();
    cyc     = 0;
    start   = 1'b0;
    data_tx = 8'h00;
  endtask

  task automatic wait_done(output int at, output int cs_hi);
    at    = -1;
    cs_hi = 0;
    for (int i = 0; i < 200 && at < 0; i++) begin
      step();
      if (done) at = cyc;
      else if (cs) cs_hi++;
    end
  endtask

  initial begin
    int done_at, cs_hi, fall_at, n, r0, b0, d1, d2;
    logic [7:0] rx_first;
    nreset = 1'b0; start = 1'b0; start1 = 1'b0; loop = 1'b1;
    data_tx = 8'h00; data_tx1 = 8'h00; rx_first = 8'h00;
    #12;
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", data_rx, 0);
    nreset = 1'b1;
    steps(2);

    // Loopback 0xA5
    accept(8'hA5);
    chk("t1_busy_acc", busy, 1);
    chk("t1_cs_c0", cs, 1);
    wait_done(done_at, cs_hi);
    chk("t1_done_cyc", done_at, 69);
    chk("t1_cs_low", cs_hi, 0);
    chk("t1_cs_rise", cs, 1);
    chk("t1_rx", data_rx, 8'hA5);
    fall_at = -1;
    for (int i = 0; i < 20 && fall_at < 0; i++) begin
      step();
      if (!busy) fall_at = cyc;
    end
    chk("t1_busy_fall", fall_at, 73);

    // Peripheral model: send 0x81, receive 0x3C
    loop = 1'b0;
    r0 = sck_rises;
    b0 = sdo_bad;
    step();
    accept(8'h81);
    wait_done(done_at, cs_hi);
    chk("t2_done_cyc", done_at, 69);
    chk("t2_periph_rx", p_rx, 8'h81);
    chk("t2_rx", data_rx, 8'h3C);
    chk("t2_rises", sck_rises - r0, 8);
    chk("t2_sdo_stable", sdo_bad - b0, 0);
    steps(6);
    loop = 1'b1;

    // start while busy is ignored
    accept(8'h66);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (done) n++;
      if (i == 9 || i == 39) begin
        start = 1'b1; data_tx = 8'hFF;
      end else begin
        start = 1'b0; data_tx = 8'h00;
      end
    end
    chk("t3_done_count", n, 1);
    chk("t3_rx", data_rx, 8'h66);
    chk("t3_idle", busy, 0);

    // Asynchronous reset mid-frame
    accept(8'hC3);
    steps(30);
    nreset = 1'b0;
    #2;
    chk("t4_cs", cs, 1);
    chk("t4_sck", sck, 0);
    chk("t4_busy", busy, 0);
    chk("t4_rx", data_rx, 0);
    chk("t4_done", done, 0);
    #2;
    nreset = 1'b1;
    steps(2);
    accept(8'h5A);
    wait_done(done_at, cs_hi);
    chk("t4_done_cyc", done_at, 69);
    chk("t4_rx_after", data_rx, 8'h5A);
    steps(6);

    // CLK_DIV=1 loopback on the second instance
    data_tx1 = 8'h0F;
    start1 = 1'b1;
    step();
    cyc = 0;
    start1 = 1'b0;
    data_tx1 = 8'h00;
    done_at = -1;
    n = 0;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      step();
      if (done1) done_at = cyc;
      if (cyc >= 2 && cyc <= 17 && sck1 !== (cyc % 2 == 0)) n++;
    end
    chk("t5_done_cyc", done_at, 18);
    chk("t5_sck_toggle", n, 0);
    chk("t5_rx", data_rx1, 8'h0F);
    steps(4);

    // start held high across two frames: 0x12 then 0x34
    data_tx = 8'h12;
    start = 1'b1;
    step();
    cyc = 0;
    data_tx = 8'h34;
    d1 = -1;
    d2 = -1;
    cs_hi = 0;
`ifdef SPI_BURST_EN
    for (int i = 0; i < 300 && d2 < 0; i++) begin
      step();
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc; rx_first = data_rx; start = 1'b0; data_tx = 8'h00;
        end else begin
          d2 = cyc;
        end
      end else if (cs) begin
        cs_hi++;
      end
    end
    chk("t6_done1", d1, 69);
    chk("t6_done_gap", d2 - d1, 68);
    chk("t6_cs_low", cs_hi, 0);
`else
    for (int i = 0; i < 300 && d2 < 0; i++) begin
      step();
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc; rx_first = data_rx;
        end else begin
          d2 = cyc;
        end
      end
      if (d1 >= 0 && d2 < 0 && cs) cs_hi++;
      if (d1 >= 0 && !cs) start = 1'b0;
    end
    chk("t6_done1", d1, 69);
    // Re-acceptance lands on the edge after busy falls, so cs is high for CLK_DIV+2 cycles.
    chk("t6_done2", d2, 143);
    chk("t6_cs_high", cs_hi, 6);
`endif
    chk("t6_rx_first", rx_first, 8'h12);
    chk("t6_rx_second", data_rx, 8'h34);
    start = 1'b0;
    steps(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
